// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader and the fetch stage.
// The fetch stage and the loader both size the instruction memory from IMEM_ADDR_W.
package imem_loader_pkg;

  localparam int IMEM_ADDR_W    = 6;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } ld_state_e;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs a little-endian byte stream into 32-bit words.
// word_ready pulses combinationally with the transfer that completes a word.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clock,
  input  logic        resetn,
  input  logic        clear,
  input  logic        push,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_ready
);

  localparam int IDX_W = $clog2(BYTES_PER_WORD);

  logic [IDX_W-1:0]                idx_q;
  logic [BYTES_PER_WORD-1:0][7:0]  pack_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      idx_q  <= '0;
      pack_q <= '0;
    end else begin
      if (clear)
        idx_q <= '0;
      else if (push)
        idx_q <= idx_q + 1'b1;
      if (push)
        pack_q[idx_q] <= byte_in;
    end
  end

  assign word       = pack_q;
  assign word_ready = push && (idx_q == IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction memory; holds the CPU while loading.
// FSM, word address and running checksum live here; byte packing is in byte_packer.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic [31:0]       checksum
);

  localparam logic [ADDR_W:0] DEPTH_W = DEPTH[ADDR_W:0];

  ld_state_e         state_q, state_d;
  logic [ADDR_W:0]   cnt_q;
  logic [ADDR_W-1:0] addr_q, waddr_q;
  logic [31:0]       wdata_q, sum_q, pack_word;
  logic              start_acc, push, word_ready, last_word, pk_clear;

  assign start_acc = start && (word_count != '0) &&
                     ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign push      = byte_valid && byte_ready;
  assign last_word = ({1'b0, addr_q} == (cnt_q - 1'b1));
  assign pk_clear  = start_acc || (state_q == ST_WRITE);

  byte_packer u_packer (
    .clock      (clock),
    .resetn     (resetn),
    .clear      (pk_clear),
    .push       (push),
    .byte_in    (byte_in),
    .word       (pack_word),
    .word_ready (word_ready)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: if (start_acc)  state_d = ST_COLLECT;
      ST_COLLECT:       if (word_ready) state_d = ST_WRITE;
      ST_WRITE:         state_d = last_word ? ST_DONE : ST_COLLECT;
      default:          state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    byte_ready = 1'b0;
    we         = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      ST_COLLECT: begin byte_ready = 1'b1; busy = 1'b1; end
      ST_WRITE:   begin we = 1'b1;         busy = 1'b1; end
      ST_DONE:    done = 1'b1;
      default:    ;
    endcase
  end

  // Address and data hold registers keep the write port stable outside WRITE.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_q   <= '0;
      addr_q  <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      sum_q   <= '0;
    end else if (start_acc) begin
      cnt_q  <= (word_count > DEPTH_W) ? DEPTH_W : word_count;
      addr_q <= '0;
      sum_q  <= '0;
    end else if (state_q == ST_WRITE) begin
      sum_q   <= sum_q + pack_word;
      waddr_q <= addr_q;
      wdata_q <= pack_word;
      if (!last_word) addr_q <= addr_q + 1'b1;
    end
  end

  assign cpu_hold = busy;
  assign waddr    = we ? addr_q : waddr_q;
  assign wdata    = we ? pack_word : wdata_q;
  assign checksum = sum_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized directed bench for imem_loader with a word-list reference model.
module tb_imem_loader;

  localparam int AW = 6;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   word_count = '0;
  logic [7:0]    byte_in = '0;
  logic          byte_valid = 1'b0;
  logic          byte_ready, we, cpu_hold, busy, done;
  logic [AW-1:0] waddr;
  logic [31:0]   wdata, checksum;

  imem_loader #(.ADDR_W(AW)) dut (
    .clock(clock), .resetn(resetn), .start(start), .word_count(word_count),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .we(we), .waddr(waddr), .wdata(wdata), .cpu_hold(cpu_hold),
    .busy(busy), .done(done), .checksum(checksum)
  );

  always #5 clock = ~clock;

  typedef struct { int addr; logic [31:0] data; int cyc; } wr_t;

  int          ncyc = 0;
  int          nacc = 0;
  int          nchk = 0;
  int          npass = 0;
  wr_t         wq[$];
  int          acc_q[$];
  logic [31:0] tbmem [64];
  logic [31:0] exp_w [64];

  // Observer: log accepted-byte cycles and memory writes.
  always @(negedge clock) begin
    ncyc <= ncyc + 1;
    if (byte_valid && byte_ready) begin
      nacc <= nacc + 1;
      acc_q.push_back(ncyc);
    end
    if (we) begin
      wq.push_back('{int'(waddr), wdata, ncyc});
      tbmem[waddr] <= wdata;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ctl"}, {byte_ready, we, cpu_hold, busy, done}, 5'b0);
    chk({tag, "_waddr"}, waddr, 0);
    chk({tag, "_wdata"}, wdata, 0);
    chk({tag, "_sum"}, checksum, 0);
  endtask

  // Called at a negedge; start is seen by the next rising edge.
  task automatic do_start(input int cnt);
    acc_q.delete();
    wq.delete();
    start = 1'b1;
    word_count = (AW+1)'(cnt);
    @(negedge clock);
    start = 1'b0;
    chk("start_busy", {busy, cpu_hold, byte_ready}, (cnt != 0) ? 3'b111 : 3'b000);
  endtask

  task automatic push_byte(input logic [7:0] b, input bit gap, input bit pulse_start);
    int t;
    if (gap) begin
      byte_valid = 1'b0;
      if (pulse_start) begin start = 1'b1; word_count = 7'd5; end
      @(negedge clock);
      start = 1'b0;
    end
    byte_in = b;
    byte_valid = 1'b1;
    t = 0;
    while (!byte_ready && t < 40) begin @(negedge clock); t++; end
    if (!byte_ready) chk("byte_ready_wait", byte_ready, 1);
    @(negedge clock);
    byte_valid = 1'b0;
  endtask

  // mode: 0 random words, 1 i*0x01010101, 2 fixed single word
  task automatic run_load(input int cnt, input int mode, input bit gapped, input bit mid_start);
    int eff;
    logic [31:0] sum;
    eff = (cnt > 64) ? 64 : cnt;
    sum = '0;
    for (int i = 0; i < eff; i++) begin
      case (mode)
        1:       exp_w[i] = 32'(i) * 32'h01010101;
        2:       exp_w[i] = 32'h2000013C;
        default: exp_w[i] = $urandom;
      endcase
      sum += exp_w[i];
    end
    do_start(cnt);
    for (int i = 0; i < eff; i++)
      for (int b = 0; b < 4; b++)
        push_byte(exp_w[i][8*b +: 8], gapped, mid_start && i == 0 && b == 2);
    chk("last_we", we, 1);
    @(negedge clock);
    chk("end_done_hold", {done, cpu_hold, busy, byte_ready}, 4'b1000);
    chk("end_sum", checksum, sum);
    #1;
    chk("nwrites", wq.size(), eff);
    for (int i = 0; i < eff && i < wq.size(); i++) begin
      chk("wr_addr", wq[i].addr, i);
      chk("wr_data", wq[i].data, exp_w[i]);
      if (acc_q.size() > 4*i+3)
        chk("wr_latency", wq[i].cyc, acc_q[4*i+3] + 1);
    end
  endtask

  initial begin
    int nacc0;
    logic [31:0] old1, old2;

    // reset then idle
    @(negedge clock);
    @(negedge clock);
    chk_idle_outputs("in_reset");
    resetn = 1'b1;
    @(negedge clock);
    chk_idle_outputs("after_reset");
    byte_valid = 1'b1;
    byte_in = 8'hA5;
    repeat (4) @(negedge clock);
    #1;
    chk("idle_no_consume", nacc, 0);
    chk("idle_ready", byte_ready, 0);
    byte_valid = 1'b0;
    @(negedge clock);

    // single word
    run_load(1, 2, 1'b0, 1'b0);
    chk("single_sum_const", checksum, 32'h2000013C);
    chk("single_wdata_hold", wdata, 32'h2000013C);
    nacc0 = nacc;
    byte_valid = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    chk("done_sticky", done, 1);
    chk("done_no_consume", nacc, nacc0);
    byte_valid = 1'b0;
    @(negedge clock);

    // full depth with the ramp pattern
    run_load(64, 1, 1'b0, 1'b0);
    chk("full_sum_const", checksum, 32'hE7E7E7E0);
    chk("full_waddr_hold", waddr, 63);

    // gapped stream with a start pulse mid-load
    run_load(2, 0, 1'b1, 1'b1);

    // random short loads
    for (int k = 0; k < 3; k++)
      run_load(int'($urandom_range(2, 6)), 0, 1'($urandom_range(0, 1)), 1'b0);

    // zero count from DONE and, after a reset, from IDLE
    do_start(0);
    @(negedge clock);
    chk("zero_from_done", {done, busy}, 2'b10);
    resetn = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    do_start(0);
    @(negedge clock);
    chk("zero_from_idle", {done, busy, byte_ready}, 3'b000);

    // clamp
    run_load(100, 0, 1'b0, 1'b0);

    // reset mid-load: 3 words and 2 bytes of word 3
    for (int i = 0; i < 5; i++) exp_w[i] = $urandom;
    do_start(5);
    for (int i = 0; i < 3; i++)
      for (int b = 0; b < 4; b++)
        push_byte(exp_w[i][8*b +: 8], 1'b0, 1'b0);
    push_byte(exp_w[3][7:0], 1'b0, 1'b0);
    push_byte(exp_w[3][15:8], 1'b0, 1'b0);
    old1 = exp_w[1];
    old2 = exp_w[2];
    resetn = 1'b0;
    #1;
    chk_idle_outputs("mid_reset");
    @(negedge clock);
    resetn = 1'b1;
    #1;
    chk("abort_nwrites", wq.size(), 3);
    @(negedge clock);
    run_load(1, 0, 1'b0, 1'b0);
    chk("keep_word1", tbmem[1], old1);
    chk("keep_word2", tbmem[2], old2);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
